// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types and helpers for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        ROT_L = 2'd1,
        ROT_R = 2'd2,
        BLINK = 2'd3
    } led_mode_t;

    // Power-on pattern: every LED dark except bit 0 (active-low drive).
    function automatic logic [31:0] seed(input int unsigned led_w);
        return (32'hFFFF_FFFF >> (32 - led_w)) & ~32'd1;
    endfunction

    function automatic led_mode_t next_mode(input led_mode_t m);
        return led_mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_debounce.sv
// Two-flop synchronizer plus stability counter for one active-low button.
module button_debounce #(
    parameter int unsigned CYCLES = 270_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level,
    output logic press
);

    logic [1:0]  sync;
    logic [31:0] cnt;
    logic        differ;
    logic        accept;

    assign differ = (sync[1] != level);
    assign accept = differ && (cnt == 32'(CYCLES - 1));
    // Pulse in the cycle the new low level is being accepted.
    assign press  = accept && !sync[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], btn_n};
            if (!differ) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Button-driven LED pattern sequencer: mode FSM, speed select, step timer and LED shifter.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned LED_W           = 3,
    parameter int unsigned STEP_CYCLES     = 13_500_000,
    parameter int unsigned DEBOUNCE_CYCLES = 270_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             button_0,
    input  logic             button_1,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic             step_pulse
);

    localparam logic [LED_W-1:0] SEED = LED_W'(seed(LED_W));

    led_mode_t        mode_q;
    logic [1:0]       speed;
    logic [31:0]      cnt;
    logic [31:0]      period;
    logic             tick;
    logic             mode_press;
    logic             speed_press;
    logic             lvl0;
    logic             lvl1;
    logic             unused_levels;
    logic [LED_W-1:0] led_step;
    logic [LED_W-1:0] led_load;

    button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (button_0),
        .level (lvl0),
        .press (mode_press)
    );

    button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_speed (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (button_1),
        .level (lvl1),
        .press (speed_press)
    );

    // Only the press events matter here; accepted levels are left unused.
    assign unused_levels = lvl0 ^ lvl1;

    assign period = 32'(STEP_CYCLES) >> speed;
    assign tick   = (mode_q != STOP) && (cnt == period - 32'd1);
    assign mode   = mode_q;

    always_comb begin
        led_step = led;
        case (mode_q)
            ROT_L:   led_step = {led[LED_W-2:0], led[LED_W-1]};
            ROT_R:   led_step = {led[0], led[LED_W-1:1]};
            BLINK:   led_step = ~led;
            default: led_step = led;
        endcase
    end

    always_comb begin
        led_load = led;
        case (mode_q)
            ROT_R:   led_load = '0;
            BLINK:   led_load = SEED;
            default: led_load = led;
        endcase
    end

    // A press always wins over a coincident tick and restarts the step timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= STOP;
            speed      <= 2'd0;
            cnt        <= '0;
            led        <= SEED;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            if (mode_press || speed_press) begin
                cnt <= '0;
                if (mode_press) begin
                    mode_q <= next_mode(mode_q);
                    led    <= led_load;
                end
                if (speed_press) begin
                    speed <= speed + 2'd1;
                end
            end else if (mode_q == STOP) begin
                cnt <= '0;
            end else if (tick) begin
                cnt        <= '0;
                led        <= led_step;
                step_pulse <= 1'b1;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with short debounce and step periods.
module tb_led_pattern_sequencer;

    logic       clk;
    logic       rst_n;
    logic       button_0;
    logic       button_1;
    logic [2:0] led;
    logic [1:0] mode;
    logic       step_pulse;

    int vecs = 0;
    int errs = 0;

    led_pattern_sequencer #(
        .LED_W           (3),
        .STEP_CYCLES     (16),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .button_0   (button_0),
        .button_1   (button_1),
        .led        (led),
        .mode       (mode),
        .step_pulse (step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n edges and settle just past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!step_pulse && n < 200);
    endtask

    // Hold a button low long enough for its press to be applied, then release.
    task automatic press(input int which);
        if (which == 0) button_0 = 1'b0;
        else            button_1 = 1'b0;
        cyc(6);
        button_0 = 1'b1;
        button_1 = 1'b1;
    endtask

    task automatic idle(input int n, input logic [2:0] ref_led, input logic [1:0] ref_mode,
                        output int pulses, output int changes);
        pulses  = 0;
        changes = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1);
            if (step_pulse) pulses++;
            if (led !== ref_led || mode !== ref_mode) changes++;
        end
    endtask

    initial begin
        int n;
        int pulses;
        int changes;

        rst_n    = 1'b0;
        button_0 = 1'b1;
        button_1 = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        chk("rst_led", 32'(led), 32'h6);
        chk("rst_mode", 32'(mode), 32'h0);
        chk("rst_step", 32'(step_pulse), 32'h0);
        idle(200, 3'b110, 2'd0, pulses, changes);
        chk("idle_pulses", pulses, 0);
        chk("idle_changes", changes, 0);

        // Short glitch must be ignored; a long hold lands 6 cycles after the fall.
        button_0 = 1'b0;
        cyc(3);
        button_0 = 1'b1;
        cyc(10);
        chk("glitch_mode", 32'(mode), 32'h0);
        button_0 = 1'b0;
        cyc(5);
        chk("deb_early_mode", 32'(mode), 32'h0);
        cyc(1);
        chk("deb_mode", 32'(mode), 32'h1);
        chk("deb_led", 32'(led), 32'h6);
        cyc(4);
        button_0 = 1'b1;

        wait_step(n);
        chk("rotl_first_gap", n, 12);
        chk("rotl_led0", 32'(led), 32'h5);
        wait_step(n);
        chk("rotl_gap1", n, 16);
        chk("rotl_led1", 32'(led), 32'h3);
        wait_step(n);
        chk("rotl_gap2", n, 16);
        chk("rotl_led2", 32'(led), 32'h6);

        press(0);
        chk("rotr_mode", 32'(mode), 32'h2);
        chk("rotr_led_keep", 32'(led), 32'h6);
        wait_step(n);
        chk("rotr_gap0", n, 16);
        chk("rotr_led0", 32'(led), 32'h3);
        wait_step(n);
        chk("rotr_gap1", n, 16);
        chk("rotr_led1", 32'(led), 32'h5);

        press(1);
        wait_step(n);
        chk("speed1_period", n, 8);
        cyc(8);
        press(1);
        wait_step(n);
        chk("speed2_period", n, 4);
        cyc(8);
        press(1);
        wait_step(n);
        chk("speed3_period", n, 2);
        cyc(8);
        press(1);
        wait_step(n);
        chk("speed_wrap_period", n, 16);

        press(0);
        chk("blink_mode", 32'(mode), 32'h3);
        chk("blink_led_load", 32'(led), 32'h0);
        cyc(8);
        wait_step(n);
        chk("blink_gap0", n, 8);
        chk("blink_led0", 32'(led), 32'h7);
        wait_step(n);
        chk("blink_gap1", n, 16);
        chk("blink_led1", 32'(led), 32'h0);

        press(0);
        chk("stop_mode", 32'(mode), 32'h0);
        chk("stop_led_seed", 32'(led), 32'h6);
        idle(50, 3'b110, 2'd0, pulses, changes);
        chk("stop_pulses", pulses, 0);
        chk("stop_changes", changes, 0);

        // Second press pulse is timed to land on the cycle ROT_L would tick.
        press(0);
        chk("coll_mode1", 32'(mode), 32'h1);
        cyc(10);
        press(0);
        chk("coll_mode2", 32'(mode), 32'h2);
        chk("coll_led_norot", 32'(led), 32'h6);
        chk("coll_step", 32'(step_pulse), 32'h0);
        wait_step(n);
        chk("coll_restart_gap", n, 16);
        chk("coll_led_after", 32'(led), 32'h3);

        press(0);
        chk("pre_rst_mode", 32'(mode), 32'h3);
        cyc(8);
        press(1);
        cyc(4);
        rst_n = 1'b0;
        cyc(1);
        chk("midrst_led", 32'(led), 32'h6);
        chk("midrst_mode", 32'(mode), 32'h0);
        chk("midrst_step", 32'(step_pulse), 32'h0);
        rst_n = 1'b1;
        cyc(2);
        press(0);
        chk("post_rst_mode", 32'(mode), 32'h1);
        wait_step(n);
        chk("post_rst_speed0_gap", n, 16);
        chk("post_rst_led", 32'(led), 32'h5);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
